// File: rtl/argmax_vec_pkg.sv
// rtl/argmax_vec_pkg.sv - shared state encoding and sizing helper for argmax_vec
package argmax_vec_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH,
    S_FINISH
  } state_t;

  // Bit width able to index v items, never less than one bit.
  function automatic int min1_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// rtl/argmax_lane_reduce.sv - combinational lane tree picking the extreme valid lane
module argmax_lane_reduce
  import argmax_vec_pkg::*;
#(
  parameter int PORT_W = 8,
  parameter int LANES  = 4,
  localparam int LW    = min1_clog2(LANES),
  localparam int LOG   = $clog2(LANES)
) (
  input  logic [LANES*PORT_W-1:0] vals,
  input  logic [LANES-1:0]        valid,
  input  logic                    mode_min,
  output logic signed [PORT_W-1:0] win_val,
  output logic [LW-1:0]           win_lane,
  output logic                    any_valid
);

  // Level 0 holds the lanes; each higher level halves the candidates.
  for (genvar l = 0; l <= LOG; l++) begin : lvl
    localparam int N = LANES >> l;
    logic signed [PORT_W-1:0] v [N];
    logic [LW-1:0]            ix [N];
    logic                     ok [N];

    if (l == 0) begin : leaf
      for (genvar j = 0; j < N; j++) begin : ln
        assign v[j]  = vals[j*PORT_W +: PORT_W];
        assign ix[j] = LW'(j);
        assign ok[j] = valid[j];
      end
    end else begin : node
      for (genvar j = 0; j < N; j++) begin : nd
        // The right (higher) lane only wins when strictly better, so ties keep the lower lane.
        logic pick_r;
        assign pick_r = lvl[l-1].ok[2*j+1] &&
                        (!lvl[l-1].ok[2*j] ||
                         (mode_min ? (lvl[l-1].v[2*j+1] < lvl[l-1].v[2*j])
                                   : (lvl[l-1].v[2*j+1] > lvl[l-1].v[2*j])));
        assign v[j]  = pick_r ? lvl[l-1].v[2*j+1]  : lvl[l-1].v[2*j];
        assign ix[j] = pick_r ? lvl[l-1].ix[2*j+1] : lvl[l-1].ix[2*j];
        assign ok[j] = lvl[l-1].ok[2*j] | lvl[l-1].ok[2*j+1];
      end
    end
  end

  assign win_val   = lvl[LOG].v[0];
  assign win_lane  = lvl[LOG].ix[0];
  assign any_valid = lvl[LOG].ok[0];

endmodule

// File: rtl/argmax_vec.sv
// rtl/argmax_vec.sv - multi-lane runtime-configurable argmax/argmin scan engine
module argmax_vec
  import argmax_vec_pkg::*;
#(
  parameter int PORT_W          = 8,
  parameter int LANES           = 4,
  parameter int MAX_ELTS        = 16,
  parameter int ADDR_DATA_DELAY = 2,
  localparam int WORDS          = (MAX_ELTS + LANES - 1) / LANES,
  localparam int IADDR_W        = min1_clog2(WORDS),
  localparam int EIDX_W         = $clog2(MAX_ELTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode_min,
  input  logic [EIDX_W-1:0]       n_elts,
  output logic                    busy,
  output logic                    done,
  output logic [IADDR_W-1:0]      addri,
  input  logic [LANES*PORT_W-1:0] din,
  output logic [EIDX_W-1:0]       maxidx,
  output logic [PORT_W-1:0]       maxval,
  output logic                    found
);

  localparam int LW = min1_clog2(LANES);
  localparam int MW = IADDR_W + LW + 1;
  localparam int D  = ADDR_DATA_DELAY;
  localparam logic signed [PORT_W-1:0] INT_MIN = {1'b1, {(PORT_W-1){1'b0}}};
  localparam logic signed [PORT_W-1:0] INT_MAX = {1'b0, {(PORT_W-1){1'b1}}};

  state_t                   state;
  logic                     mode_q;
  logic [EIDX_W-1:0]        n_q;
  logic [IADDR_W-1:0]       last_q;
  logic signed [PORT_W-1:0] best_v;
  logic [EIDX_W-1:0]        best_i;
  logic                     have;

  logic [D-1:0]             tok_v;
  logic [IADDR_W-1:0]       tok_w [D];

  logic [EIDX_W-1:0]        n_clamp;
  logic [EIDX_W:0]          wdiv;
  logic [IADDR_W-1:0]       words_m1;
  logic                     out_v;
  logic [IADDR_W-1:0]       out_w;
  logic [LANES-1:0]         lane_ok;
  logic signed [PORT_W-1:0] red_v;
  logic [LW-1:0]            red_lane;
  logic                     red_any;
  logic                     better;
  logic                     take;
  logic [EIDX_W-1:0]        cand_i;
  logic                     pending;

  assign n_clamp  = (n_elts > EIDX_W'(MAX_ELTS)) ? EIDX_W'(MAX_ELTS) : n_elts;
  assign wdiv     = ({1'b0, n_clamp} + (EIDX_W+1)'(LANES - 1)) / (EIDX_W+1)'(LANES);
  assign words_m1 = IADDR_W'(wdiv - (EIDX_W+1)'(1));

  assign out_v = tok_v[D-1];
  assign out_w = tok_w[D-1];

  // Mask lanes whose element index lies at or beyond the run length.
  always_comb begin
    lane_ok = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_ok[j] = out_v && ((MW'(out_w) * MW'(LANES) + MW'(j)) < MW'(n_q));
    end
  end

  argmax_lane_reduce #(
    .PORT_W (PORT_W),
    .LANES  (LANES)
  ) u_reduce (
    .vals      (din),
    .valid     (lane_ok),
    .mode_min  (mode_q),
    .win_val   (red_v),
    .win_lane  (red_lane),
    .any_valid (red_any)
  );

  assign cand_i = EIDX_W'(MW'(out_w) * MW'(LANES) + MW'(red_lane));
  assign better = mode_q ? (red_v < best_v) : (red_v > best_v);
  // First valid element is always taken so an element equal to the seed value still wins.
  assign take   = out_v && red_any && (!have || better);

  // Tokens still travelling toward the compare stage, excluding the one consumed this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      pending = pending | tok_v[i];
    end
  end

  // Delay line carrying a valid bit and word tag alongside each issued address.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_v <= '0;
      for (int i = 0; i < D; i++) tok_w[i] <= '0;
    end else begin
      tok_v[0] <= (state == S_ISSUE);
      tok_w[0] <= addri;
      for (int i = 1; i < D; i++) begin
        tok_v[i] <= tok_v[i-1];
        tok_w[i] <= tok_w[i-1];
      end
    end
  end

  // Control FSM, running-best tracker and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      busy   <= 1'b0;
      addri  <= '0;
      maxidx <= '0;
      maxval <= INT_MIN;
      found  <= 1'b0;
      mode_q <= 1'b0;
      n_q    <= '0;
      last_q <= '0;
      best_v <= INT_MIN;
      best_i <= '0;
      have   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (take) begin
        best_v <= red_v;
        best_i <= cand_i;
        have   <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          busy  <= 1'b0;
          addri <= '0;
          if (start) begin
            busy   <= 1'b1;
            mode_q <= mode_min;
            n_q    <= n_clamp;
            last_q <= words_m1;
            best_v <= mode_min ? INT_MAX : INT_MIN;
            best_i <= '0;
            have   <= 1'b0;
            state  <= (n_clamp == '0) ? S_FINISH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (addri == last_q) begin
            addri <= '0;
            state <= S_FLUSH;
          end else begin
            addri <= addri + IADDR_W'(1);
          end
        end
        S_FLUSH: begin
          if (!pending) state <= S_FINISH;
        end
        S_FINISH: begin
          done   <= 1'b1;
          maxidx <= best_i;
          maxval <= best_v;
          found  <= (n_q != '0);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
